// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and the round-robin pick used by the uart arbiters.
// rr_pick is written for up to MAX_REQ requesters so it can be reused unchanged.
package uart_tx_arbiter_pkg;

    localparam int MAX_REQ = 16;
    localparam int IDX_W   = 4;

    typedef enum logic [1:0] {
        ARB,
        LAUNCH,
        WAIT_DONE
    } arb_state_t;

    typedef struct packed {
        logic             found;
        logic [IDX_W-1:0] idx;
    } rr_pick_t;

    // First valid index strictly after ptr, wrapping modulo n.
    function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0] valid,
                                         input logic [IDX_W-1:0]   ptr,
                                         input int                 n);
        rr_pick_t r;
        int       j;
        r = '0;
        for (int k = 1; k <= MAX_REQ; k++) begin
            j = (int'(ptr) + k) % n;
            if (k <= n && !r.found && valid[j]) begin
                r.found = 1'b1;
                r.idx   = IDX_W'(j);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester byte streams plus the transmitter launch/complete handshake.
// The arbiter is the slave of this bundle; clients and transmitter drive the master side.
interface uart_tx_arbiter_if #(
    parameter int N = 4
);
    logic [N-1:0]   req_valid;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   req_last;
    logic [N-1:0]   req_ready;
    logic           tx_start;
    logic [7:0]     tx_data;
    logic           tx_busy;
    logic           tx_done;

    modport master (
        output req_valid, req_data, req_last, tx_busy, tx_done,
        input  req_ready, tx_start, tx_data
    );

    modport slave (
        input  req_valid, req_data, req_last, tx_busy, tx_done,
        output req_ready, tx_start, tx_data
    );
endinterface

// File: rtl/uart_tx_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first valid requester after the pointer.
// Kept free of arbiter state so the rx dispatcher can share it.
module rr_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]         valid,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [$clog2(N)-1:0] grant_idx,
    output logic                 found
);
    localparam int GW = $clog2(N);

    rr_pick_t pick;

    always_comb begin
        pick      = rr_pick(MAX_REQ'(valid), IDX_W'(ptr), N);
        grant_idx = GW'(pick.idx);
        found     = pick.found;
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart transmitter among N requesters with per-packet round-robin
// grants; a lock holds the owner until last, burst limit or idle timeout.
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int N            = 4,
    parameter int MAX_BURST    = 16,
    parameter int LOCK_TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 reset,
    uart_tx_arbiter_if.slave     bus,
    output logic [$clog2(N)-1:0] grant_id,
    output logic                 locked,
    output logic [N-1:0]         sent
);
    localparam int GW = $clog2(N);
    localparam int BW = $clog2(MAX_BURST + 1);
    localparam int IW = $clog2(LOCK_TIMEOUT + 1);
    localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);
    localparam logic [IW-1:0] IDLE_LAST  = IW'(LOCK_TIMEOUT - 1);

    arb_state_t     state, next_state;
    logic [GW-1:0]  ptr, rr_idx, cand;
    logic           rr_found, cand_ok, accept, owner_idle, cand_last;
    logic [7:0]     cand_data;
    logic [N-1:0]   req_ready_c;
    logic [BW-1:0]  burst_cnt;
    logic [IW-1:0]  idle_cnt;
    logic           tx_start_q;
    logic [7:0]     tx_data_q;

    rr_arbiter #(.N(N)) u_rr (
        .valid     (bus.req_valid),
        .ptr       (ptr),
        .grant_idx (rr_idx),
        .found     (rr_found)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= ARB;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            ARB:       if (accept) next_state = LAUNCH;
            LAUNCH:    next_state = WAIT_DONE;
            WAIT_DONE: if (bus.tx_done) next_state = ARB;
            default:   next_state = ARB;
        endcase
    end

    // A held lock restricts the candidate to the owner; otherwise round-robin.
    always_comb begin
        cand        = locked ? grant_id : rr_idx;
        cand_ok     = locked ? bus.req_valid[grant_id] : rr_found;
        accept      = (state == ARB) && !bus.tx_busy && cand_ok;
        req_ready_c = accept ? (N'(1) << cand) : '0;
        cand_data   = bus.req_data[{cand, 3'b000} +: 8];
        cand_last   = bus.req_last[cand];
        owner_idle  = (state == ARB) && locked && !bus.req_valid[grant_id];
    end

    assign bus.req_ready = req_ready_c;
    assign bus.tx_start  = tx_start_q;
    assign bus.tx_data   = tx_data_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_start_q <= 1'b0;
            tx_data_q  <= '0;
            grant_id   <= '0;
            ptr        <= GW'(N - 1);
            sent       <= '0;
        end else begin
            tx_start_q <= accept;
            if (accept) begin
                tx_data_q <= cand_data;
                grant_id  <= cand;
                if (!locked) ptr <= cand;
            end
            sent <= (state == WAIT_DONE && bus.tx_done) ? (N'(1) << grant_id) : '0;
        end
    end

    // Burst and idle counters clear rather than wrap whenever the lock drops.
    always_ff @(posedge clk) begin
        if (reset) begin
            locked    <= 1'b0;
            burst_cnt <= '0;
            idle_cnt  <= '0;
        end else if (accept) begin
            idle_cnt <= '0;
            if (cand_last || burst_cnt == BURST_LAST) begin
                locked    <= 1'b0;
                burst_cnt <= '0;
            end else begin
                locked    <= 1'b1;
                burst_cnt <= burst_cnt + 1'b1;
            end
        end else if (owner_idle) begin
            if (idle_cnt == IDLE_LAST) begin
                locked    <= 1'b0;
                idle_cnt  <= '0;
                burst_cnt <= '0;
            end else begin
                idle_cnt <= idle_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: queued requesters, a 20-cycle transmitter model
// and a transaction-level reference of the grant/lock rules.
module tb_uart_tx_arbiter;
    localparam int N            = 4;
    localparam int MAX_BURST    = 16;
    localparam int LOCK_TIMEOUT = 255;
    localparam int FRAME        = 20;

    logic         clk;
    logic         reset;
    logic [1:0]   grant_id;
    logic         locked;
    logic [N-1:0] sent;

    uart_tx_arbiter_if #(.N(N)) bus ();

    uart_tx_arbiter #(
        .N            (N),
        .MAX_BURST    (MAX_BURST),
        .LOCK_TIMEOUT (LOCK_TIMEOUT)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .grant_id (grant_id),
        .locked   (locked),
        .sent     (sent)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic tm_busy, tm_done, stall_busy, spur_done;
    int   tm_cnt, frames_open;

    assign bus.tx_busy = tm_busy | stall_busy;
    assign bus.tx_done = tm_done | spur_done;

    // Transmitter: busy from the cycle after tx_start, done pulse FRAME cycles later.
    always @(posedge clk) begin
        if (reset) begin
            tm_busy     <= 1'b0;
            tm_done     <= 1'b0;
            tm_cnt      <= 0;
            frames_open <= 0;
        end else begin
            tm_done     <= 1'b0;
            frames_open <= frames_open + (bus.tx_start ? 1 : 0) - (tm_done ? 1 : 0);
            if (bus.tx_start) begin
                tm_busy <= 1'b1;
                tm_cnt  <= FRAME - 1;
            end else if (tm_cnt > 0) begin
                tm_cnt <= tm_cnt - 1;
                if (tm_cnt == 1) begin
                    tm_done <= 1'b1;
                    tm_busy <= 1'b0;
                end
            end
        end
    end

    logic [8:0]   req_q [N][$];
    int           id_trace[$];
    bit           lock_trace[$];
    int           sent_trace[$];
    int           ready_cycles;
    int           assert_cnt, fail_cnt;
    bit           rst_req, stall_req, spur_req;

    int           m_phase, m_ptr, m_owner, m_burst, m_idle;
    bit           m_locked;
    logic [7:0]   m_data;
    logic [N-1:0] m_sent;

    int           s2_exp [5] = '{0, 1, 2, 3, 0};
    int           s3_exp [4] = '{1, 1, 1, 2};
    int           s3_lock[4] = '{1, 1, 0, 0};
    int           idle_seen, n, exp_id;
    bit           got, drained;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assert_cnt++;
        assert (obs === exp) else begin
            fail_cnt++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_phase  = 0;
        m_ptr    = N - 1;
        m_owner  = 0;
        m_burst  = 0;
        m_idle   = 0;
        m_locked = 1'b0;
        m_data   = '0;
        m_sent   = '0;
    endtask

    task automatic clear_traces();
        id_trace.delete();
        lock_trace.delete();
        sent_trace.delete();
        ready_cycles = 0;
    endtask

    function automatic int id_at(input int k);
        return (k < id_trace.size()) ? id_trace[k] : -1;
    endfunction

    function automatic int lock_at(input int k);
        return (k < lock_trace.size()) ? int'(lock_trace[k]) : -1;
    endfunction

    task automatic push(input int id, input logic [7:0] d, input bit last);
        req_q[id].push_back({last, d});
    endtask

    task automatic apply_stimulus();
        logic [8:0] head;
        reset      = rst_req;
        stall_busy = stall_req;
        spur_done  = spur_req;
        for (int i = 0; i < N; i++) begin
            if (rst_req) req_q[i].delete();
            if (req_q[i].size() > 0) begin
                head                  = req_q[i][0];
                bus.req_valid[i]      = 1'b1;
                bus.req_data[8*i +: 8] = head[7:0];
                bus.req_last[i]       = head[8];
            end else begin
                bus.req_valid[i]      = 1'b0;
                bus.req_data[8*i +: 8] = 8'h00;
                bus.req_last[i]       = 1'b0;
            end
        end
    endtask

    // Reference: owner keeps the line while locked, else next valid after the last winner.
    task automatic check_output();
        int           cand;
        bit           ok;
        logic [N-1:0] exp_ready, hs, nsent;
        ok   = 1'b0;
        cand = m_owner;
        if (m_locked) ok = bus.req_valid[m_owner];
        else begin
            for (int k = 1; k <= N; k++) begin
                if (!ok && bus.req_valid[(m_ptr + k) % N]) begin
                    ok   = 1'b1;
                    cand = (m_ptr + k) % N;
                end
            end
        end
        ok        = ok && (m_phase == 0) && !bus.tx_busy;
        exp_ready = '0;
        if (ok) exp_ready[cand] = 1'b1;

        if (!reset) begin
            check_val("req_ready", 32'(bus.req_ready), 32'(exp_ready));
            check_val("tx_start", 32'(bus.tx_start), 32'(m_phase == 1));
            check_val("tx_data", 32'(bus.tx_data), 32'(m_data));
            check_val("grant_id", 32'(grant_id), 32'(m_owner));
            check_val("locked", 32'(locked), 32'(m_locked));
            check_val("sent", 32'(sent), 32'(m_sent));

            hs = bus.req_ready & bus.req_valid;
            if (hs != '0) ready_cycles++;
            for (int i = 0; i < N; i++) begin
                if (hs[i]) begin
                    id_trace.push_back(i);
                    void'(req_q[i].pop_front());
                end
            end
            if (bus.tx_start) begin
                check_val("start_overlap", 32'(frames_open), 32'd0);
                lock_trace.push_back(locked);
            end
            if (sent != '0) sent_trace.push_back(int'(sent));
        end

        if (reset) model_reset();
        else begin
            nsent = '0;
            case (m_phase)
                0: begin
                    if (ok) begin
                        m_data  = bus.req_data[8*cand +: 8];
                        m_owner = cand;
                        if (!m_locked) m_ptr = cand;
                        m_idle  = 0;
                        if (bus.req_last[cand] || m_burst + 1 == MAX_BURST) begin
                            m_locked = 1'b0;
                            m_burst  = 0;
                        end else begin
                            m_locked = 1'b1;
                            m_burst++;
                        end
                        m_phase = 1;
                    end else if (m_locked && !bus.req_valid[m_owner]) begin
                        m_idle++;
                        if (m_idle == LOCK_TIMEOUT) begin
                            m_locked = 1'b0;
                            m_idle   = 0;
                            m_burst  = 0;
                        end
                    end
                end
                1: m_phase = 2;
                default: begin
                    if (bus.tx_done) begin
                        nsent[m_owner] = 1'b1;
                        m_phase = 0;
                    end
                end
            endcase
            m_sent = nsent;
        end
    endtask

    task automatic step();
        @(negedge clk);
        apply_stimulus();
        #1;
        check_output();
    endtask

    task automatic drain(input string tag, input int budget);
        int  cnt;
        bit  done;
        cnt  = 0;
        done = 1'b0;
        while (!done && cnt < budget) begin
            step();
            cnt++;
            done = (m_phase == 0);
            for (int i = 0; i < N; i++) if (req_q[i].size() > 0) done = 1'b0;
        end
        assert_cnt++;
        assert (done) else begin
            fail_cnt++;
            $error("[TB] FAIL %s: observed timeout after %0d cycles required drained", tag, cnt);
        end
    endtask

    task automatic do_reset();
        rst_req = 1'b1;
        step();
        step();
        rst_req = 1'b0;
    endtask

    initial begin
        assert_cnt    = 0;
        fail_cnt      = 0;
        rst_req       = 1'b0;
        stall_req     = 1'b0;
        spur_req      = 1'b0;
        reset         = 1'b1;
        stall_busy    = 1'b0;
        spur_done     = 1'b0;
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.req_last  = '0;
        model_reset();
        clear_traces();
        do_reset();

        $display("[TB] single byte from requester 0");
        clear_traces();
        push(0, 8'h55, 1'b1);
        drain("s1_drain", 200);
        step();
        check_val("s1_ready_cycles", 32'(ready_cycles), 32'd1);
        check_val("s1_grant", 32'(id_at(0)), 32'd0);
        check_val("s1_tx_data", 32'(bus.tx_data), 32'h55);
        check_val("s1_locked", 32'(lock_at(0)), 32'd0);
        check_val("s1_sent_count", 32'(sent_trace.size()), 32'd1);
        if (sent_trace.size() > 0) check_val("s1_sent", 32'(sent_trace[0]), 32'd1);

        $display("[TB] all requesters, single-byte packets");
        do_reset();
        clear_traces();
        push(0, 8'hA0, 1'b1);
        push(0, 8'hA4, 1'b1);
        for (int i = 1; i < N; i++) push(i, 8'(8'hA0 + i), 1'b1);
        drain("s2_drain", 1000);
        check_val("s2_count", 32'(id_trace.size()), 32'd5);
        for (int k = 0; k < 5; k++) check_val($sformatf("s2_order%0d", k), 32'(id_at(k)), 32'(s2_exp[k]));

        $display("[TB] three-byte packet holds the lock");
        do_reset();
        clear_traces();
        push(1, 8'h11, 1'b0);
        push(1, 8'h12, 1'b0);
        push(1, 8'h13, 1'b1);
        push(2, 8'h21, 1'b1);
        drain("s3_drain", 1000);
        for (int k = 0; k < 4; k++) begin
            check_val($sformatf("s3_order%0d", k), 32'(id_at(k)), 32'(s3_exp[k]));
            check_val($sformatf("s3_lock%0d", k), 32'(lock_at(k)), 32'(s3_lock[k]));
        end

        $display("[TB] burst limit forces release");
        do_reset();
        clear_traces();
        for (int k = 0; k < 20; k++) push(0, 8'(k), 1'b0);
        n = 0;
        while (id_trace.size() == 0 && n < 10) begin
            step();
            n++;
        end
        push(3, 8'h33, 1'b1);
        drain("s4_drain", 2000);
        check_val("s4_count", 32'(id_trace.size()), 32'd21);
        for (int k = 0; k < 21; k++) begin
            exp_id = (k == 16) ? 3 : 0;
            check_val($sformatf("s4_order%0d", k), 32'(id_at(k)), 32'(exp_id));
        end
        check_val("s4_lock_byte16", 32'(lock_at(15)), 32'd0);
        check_val("s4_lock_byte20", 32'(lock_at(20)), 32'd1);

        $display("[TB] idle owner lock timeout");
        clear_traces();
        push(2, 8'h22, 1'b1);
        idle_seen = 0;
        n         = 0;
        got       = 1'b0;
        while (!got && n < 400) begin
            step();
            n++;
            if (bus.req_ready != '0) got = 1'b1;
            else if (locked && !bus.tx_start && frames_open == 0) idle_seen++;
        end
        check_val("s5_accept", 32'(got), 32'd1);
        check_val("s5_idle_cycles", 32'(idle_seen), 32'(LOCK_TIMEOUT));
        check_val("s5_ready", 32'(bus.req_ready), 32'b0100);
        check_val("s5_unlocked", 32'(locked), 32'd0);
        drain("s5_drain", 200);

        $display("[TB] reset mid-frame then spurious done");
        push(1, 8'h61, 1'b1);
        n = 0;
        while (!bus.tx_start && n < 10) begin
            step();
            n++;
        end
        for (int k = 0; k < 5; k++) step();
        rst_req = 1'b1;
        step();
        rst_req = 1'b0;
        step();
        check_val("s6_req_ready", 32'(bus.req_ready), 32'd0);
        check_val("s6_tx_start", 32'(bus.tx_start), 32'd0);
        check_val("s6_tx_data", 32'(bus.tx_data), 32'd0);
        check_val("s6_grant", 32'(grant_id), 32'd0);
        check_val("s6_locked", 32'(locked), 32'd0);
        check_val("s6_sent", 32'(sent), 32'd0);
        clear_traces();
        spur_req = 1'b1;
        step();
        spur_req = 1'b0;
        step();
        step();
        check_val("s6_spurious_sent", 32'(sent_trace.size()), 32'd0);

        $display("[TB] randomized traffic with stalls and spurious done");
        for (int it = 0; it < 60; it++) begin
            push(int'($urandom_range(0, N - 1)), 8'($urandom), $urandom_range(0, 2) == 0);
            n = int'($urandom_range(0, 25));
            for (int c = 0; c < n; c++) begin
                stall_req = ($urandom_range(0, 7) == 0);
                spur_req  = (m_phase == 0) && ($urandom_range(0, 15) == 0);
                step();
            end
        end
        stall_req = 1'b0;
        spur_req  = 1'b0;
        drain("s7_drain", 20000);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end

endmodule
